// File: rtl/bus_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bus_timer: bus-slave 32-bit interval timer with wait-stated response  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module bus_timer #(
   parameter int WAIT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cs_,
   input  logic        as_,
   input  logic        rw,
   input  logic [1:0]  addr,
   input  logic [31:0] wr_data,
   output logic [31:0] rd_data,
   output logic        rdy_,
   output logic        irq
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam bit         c_no_wait   = (WAIT_CYCLES == 0);
   localparam logic [3:0] c_wait_last = c_no_wait ? 4'd0 : 4'(WAIT_CYCLES - 1);

   state_t      r_state;
   state_t      w_next;
   logic [3:0]  r_wait_cnt;
   logic [1:0]  r_addr;
   logic        r_rw;
   logic [31:0] r_wr_data;

   logic        r_start;
   logic        r_mode;
   logic        r_intr;
   logic [31:0] r_expr;
   logic [31:0] r_count;
   logic        r_rdy_n;
   logic [31:0] r_rd_data;

   logic        w_capture;
   logic        w_wait_done;
   logic        w_commit;
   logic [1:0]  w_acc_addr;
   logic        w_acc_rw;
   logic [31:0] w_acc_wdata;
   logic        w_wr_ctrl;
   logic        w_wr_intr;
   logic        w_wr_expr;
   logic        w_wr_count;
   logic        w_match;
   logic [31:0] w_rd_mux;

   assign w_capture   = (r_state == ST_IDLE) && !cs_ && !as_;
   assign w_wait_done = (r_state == ST_WAIT) && (r_wait_cnt == c_wait_last);
   assign w_commit    = (w_capture && c_no_wait) || w_wait_done;

   // With no wait states the commit edge is the capture edge, so use the live bus
   assign w_acc_addr  = (r_state == ST_IDLE) ? addr    : r_addr;
   assign w_acc_rw    = (r_state == ST_IDLE) ? rw      : r_rw;
   assign w_acc_wdata = (r_state == ST_IDLE) ? wr_data : r_wr_data;

   assign w_wr_ctrl  = w_commit && !w_acc_rw && (w_acc_addr == 2'd0);
   assign w_wr_intr  = w_commit && !w_acc_rw && (w_acc_addr == 2'd1);
   assign w_wr_expr  = w_commit && !w_acc_rw && (w_acc_addr == 2'd2);
   assign w_wr_count = w_commit && !w_acc_rw && (w_acc_addr == 2'd3);
   assign w_match    = r_start && (r_count == r_expr);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (w_capture)   w_next = c_no_wait ? ST_RESP : ST_WAIT;
         ST_WAIT: if (w_wait_done) w_next = ST_RESP;
         ST_RESP: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wait_cnt <= 4'd0;
         r_addr     <= 2'd0;
         r_rw       <= 1'b0;
         r_wr_data  <= 32'd0;
      end else begin
         if (w_capture) begin
            r_wait_cnt <= 4'd0;
            r_addr     <= addr;
            r_rw       <= rw;
            r_wr_data  <= wr_data;
         end else if (r_state == ST_WAIT) begin
            r_wait_cnt <= w_wait_done ? 4'd0 : r_wait_cnt + 4'd1;
         end
      end
   end

   // Bus writes take priority over counter side effects, except a match beats an INTR clear
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_start <= 1'b0;
         r_mode  <= 1'b0;
         r_intr  <= 1'b0;
         r_expr  <= 32'd0;
         r_count <= 32'd0;
      end else begin
         if (w_wr_ctrl) begin
            r_start <= w_acc_wdata[0];
            r_mode  <= w_acc_wdata[1];
         end else if (w_match && !r_mode) begin
            r_start <= 1'b0;
         end

         if (w_match)                          r_intr <= 1'b1;
         else if (w_wr_intr && !w_acc_wdata[0]) r_intr <= 1'b0;

         if (w_wr_expr) r_expr <= w_acc_wdata;

         if (w_wr_count)   r_count <= w_acc_wdata;
         else if (w_match) r_count <= 32'd0;
         else if (r_start) r_count <= r_count + 32'd1;
      end
   end

   always_comb begin
      w_rd_mux = 32'd0;
      case (w_acc_addr)
         2'd0:    w_rd_mux = {30'd0, r_mode, r_start};
         2'd1:    w_rd_mux = {31'd0, r_intr};
         2'd2:    w_rd_mux = r_expr;
         default: w_rd_mux = r_count;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rdy_n   <= 1'b1;
         r_rd_data <= 32'd0;
      end else begin
         r_rdy_n   <= !w_commit;
         r_rd_data <= (w_commit && w_acc_rw) ? w_rd_mux : 32'd0;
      end
   end

   assign rd_data = r_rd_data;
   assign rdy_    = r_rdy_n;
   assign irq     = r_intr;

endmodule
`default_nettype wire

// File: tb/tb_bus_timer.sv
`default_nettype none
// Testbench for bus_timer: two instances (0 and 3 wait states) checked every
// cycle against an edge-counting reference model, plus directed sequences.
module tb_bus_timer;

   localparam int W0 = 0;
   localparam int W1 = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cs_n   [2];
   logic        as_n   [2];
   logic        rw_i   [2];
   logic [1:0]  addr_i [2];
   logic [31:0] wd_i   [2];
   logic [31:0] rd_o   [2];
   logic        rdy_o  [2];
   logic        irq_o  [2];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   bus_timer #(.WAIT_CYCLES(W0)) u_dut0 (
      .clk(clk), .reset(reset), .cs_(cs_n[0]), .as_(as_n[0]), .rw(rw_i[0]),
      .addr(addr_i[0]), .wr_data(wd_i[0]), .rd_data(rd_o[0]), .rdy_(rdy_o[0]), .irq(irq_o[0]));

   bus_timer #(.WAIT_CYCLES(W1)) u_dut1 (
      .clk(clk), .reset(reset), .cs_(cs_n[1]), .as_(as_n[1]), .rw(rw_i[1]),
      .addr(addr_i[1]), .wr_data(wd_i[1]), .rd_data(rd_o[1]), .rdy_(rdy_o[1]), .irq(irq_o[1]));

   function automatic int wcfg(int i);
      return (i == 0) ? W0 : W1;
   endfunction

   // Reference model: an access captured at edge E commits at edge E+W and the
   // bus is deaf until edge E+W+1 has passed.
   typedef struct {
      logic        start;
      logic        mode;
      logic        intr;
      logic [31:0] expr;
      logic [31:0] count;
      logic        busy;
      longint      cap;
      logic [1:0]  a;
      logic        rw;
      logic [31:0] wd;
      logic        rdy;
      logic [31:0] rd;
   } model_t;

   model_t m [2];
   longint edge_no = 0;

   function automatic model_t model_reset();
      model_t n;
      n.start = 0; n.mode = 0; n.intr = 0; n.expr = 0; n.count = 0;
      n.busy = 0; n.cap = 0; n.a = 0; n.rw = 0; n.wd = 0;
      n.rdy = 1; n.rd = 0;
      return n;
   endfunction

   function automatic model_t step(model_t p, int w, longint e, logic cs, logic as,
                                   logic r, logic [1:0] a, logic [31:0] wd);
      model_t      n = p;
      logic        commit;
      logic        hit = 0;
      logic [31:0] snap;
      if (p.busy && e == p.cap + w + 1) n.busy = 0;
      else if (!p.busy && !cs && !as) begin
         n.busy = 1; n.cap = e; n.a = a; n.rw = r; n.wd = wd;
      end
      commit = n.busy && (e == n.cap + w);
      case (n.a)
         2'd0:    snap = {30'd0, p.mode, p.start};
         2'd1:    snap = {31'd0, p.intr};
         2'd2:    snap = p.expr;
         default: snap = p.count;
      endcase
      if (p.start) begin
         if (p.count == p.expr) begin
            hit = 1; n.count = 0; n.intr = 1;
            if (!p.mode) n.start = 0;
         end else n.count = p.count + 32'd1;
      end
      if (commit && !n.rw) begin
         case (n.a)
            2'd0: begin n.start = n.wd[0]; n.mode = n.wd[1]; end
            2'd1: if (!n.wd[0] && !hit) n.intr = 0;
            2'd2: n.expr = n.wd;
            default: n.count = n.wd;
         endcase
      end
      n.rdy = !commit;
      n.rd  = (commit && n.rw) ? snap : 32'd0;
      return n;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 2; i++) m[i] <= model_reset();
      end else begin
         edge_no <= edge_no + 1;
         for (int i = 0; i < 2; i++)
            m[i] <= step(m[i], wcfg(i), edge_no + 1, cs_n[i], as_n[i], rw_i[i], addr_i[i], wd_i[i]);
      end
   end

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("rdy_%0d", i), {31'd0, rdy_o[i]}, {31'd0, m[i].rdy});
         chk($sformatf("rd_data_%0d", i), rd_o[i], m[i].rd);
         chk($sformatf("irq_%0d", i), {31'd0, irq_o[i]}, {31'd0, m[i].intr});
      end
   endtask

   task automatic access(int i, logic [1:0] a, logic r, logic [31:0] wd, output logic [31:0] rdata);
      int n = 0;
      bit got = 0;
      rdata = 32'd0;
      cs_n[i] = 0; as_n[i] = 0; addr_i[i] = a; rw_i[i] = r; wd_i[i] = wd;
      while (!got && n < 20) begin
         tick();
         n++;
         if (rdy_o[i] === 1'b0) begin
            got = 1;
            rdata = rd_o[i];
         end
      end
      chk($sformatf("latency_%0d", i), 32'(n), 32'(1 + wcfg(i)));
      cs_n[i] = 1; as_n[i] = 1;
      tick();
   endtask

   task automatic wr(int i, logic [1:0] a, logic [31:0] d);
      logic [31:0] dummy;
      access(i, a, 1'b0, d, dummy);
   endtask

   task automatic rd(int i, logic [1:0] a, output logic [31:0] d);
      access(i, a, 1'b1, 32'd0, d);
   endtask

   typedef struct {
      logic [1:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   initial begin
      vec_t        tbl [7];
      logic [31:0] v;
      int          n;
      int          lows;

      tbl[0] = '{2'd2, 32'h0000_0010, 32'h0000_0010};
      tbl[1] = '{2'd0, 32'hFFFF_FFFE, 32'h0000_0002};
      tbl[2] = '{2'd0, 32'h0000_0000, 32'h0000_0000};
      tbl[3] = '{2'd3, 32'h0000_1234, 32'h0000_1234};
      tbl[4] = '{2'd1, 32'h0000_0001, 32'h0000_0000};
      tbl[5] = '{2'd2, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
      tbl[6] = '{2'd3, 32'h0000_0000, 32'h0000_0000};

      for (int i = 0; i < 2; i++) begin
         cs_n[i] = 1; as_n[i] = 1; rw_i[i] = 1; addr_i[i] = 0; wd_i[i] = 0;
      end
      repeat (3) tick();
      reset = 0;
      tick();

      // Reset values visible over the bus
      for (int i = 0; i < 2; i++)
         for (int a = 0; a < 4; a++) begin
            rd(i, 2'(a), v);
            chk($sformatf("reset_reg%0d_dut%0d", a, i), v, 32'd0);
         end

      // Table-driven write/read pairs on both instances
      for (int i = 0; i < 2; i++)
         for (int k = 0; k < 7; k++) begin
            wr(i, tbl[k].addr, tbl[k].wdata);
            rd(i, tbl[k].addr, v);
            chk($sformatf("table%0d_dut%0d", k, i), v, tbl[k].exp);
         end

      // Wait states with as_ held through RESP: exactly one response
      cs_n[1] = 0; as_n[1] = 0; addr_i[1] = 2'd0; rw_i[1] = 1;
      n = 0;
      while (rdy_o[1] !== 1'b0 && n < 20) begin tick(); n++; end
      chk("wait3_latency", 32'(n), 32'd4);
      tick();
      chk("wait3_no_second_rdy", {31'd0, rdy_o[1]}, 32'd1);
      cs_n[1] = 1; as_n[1] = 1;
      lows = 0;
      repeat (6) begin tick(); if (rdy_o[1] === 1'b0) lows++; end
      chk("wait3_single_pulse", 32'(lows), 32'd0);

      // One-shot: EXPR=5 matches six edges after start
      wr(0, 2'd3, 32'd0);
      wr(0, 2'd2, 32'd5);
      wr(0, 2'd0, 32'd1);
      n = 0;
      while (irq_o[0] !== 1'b1 && n < 20) begin tick(); n++; end
      chk("oneshot_irq_delay", 32'(n), 32'd5);
      rd(0, 2'd0, v); chk("oneshot_ctrl", v, 32'd0);
      rd(0, 2'd3, v); chk("oneshot_count", v, 32'd0);
      rd(0, 2'd1, v); chk("oneshot_intr", v, 32'd1);
      repeat (3) tick();
      rd(0, 2'd3, v); chk("oneshot_count_hold", v, 32'd0);

      // Periodic EXPR=3: matches at C+4, C+8, C+12 after the CTRL commit edge C
      wr(0, 2'd1, 32'd0);
      wr(0, 2'd3, 32'd0);
      wr(0, 2'd2, 32'd3);
      wr(0, 2'd0, 32'd3);
      repeat (3) tick();
      chk("periodic_first_irq", {31'd0, irq_o[0]}, 32'd1);
      tick();
      wr(0, 2'd1, 32'd0);
      chk("periodic_clear", {31'd0, irq_o[0]}, 32'd0);
      repeat (4) tick();
      wr(0, 2'd1, 32'd0);
      chk("periodic_clear_vs_match", {31'd0, irq_o[0]}, 32'd1);
      rd(0, 2'd1, v); chk("periodic_intr_kept", v, 32'd1);
      wr(0, 2'd0, 32'd0);

      // COUNT write on a running counter overrides the increment
      wr(0, 2'd2, 32'h0000_1000);
      wr(0, 2'd3, 32'd0);
      wr(0, 2'd0, 32'd3);
      wr(0, 2'd3, 32'h0000_0100);
      rd(0, 2'd3, v); chk("count_write_collision", v, 32'h0000_0101);
      wr(0, 2'd0, 32'd0);

      // Wrap from all-ones, then match against EXPR=0
      wr(0, 2'd1, 32'd0);
      wr(0, 2'd2, 32'd0);
      wr(0, 2'd3, 32'hFFFF_FFFF);
      wr(0, 2'd0, 32'd1);
      rd(0, 2'd3, v); chk("wrap_count", v, 32'd0);
      chk("wrap_irq", {31'd0, irq_o[0]}, 32'd1);
      rd(0, 2'd0, v); chk("wrap_ctrl_stopped", v, 32'd0);

      // Randomised accesses; the per-cycle model comparison checks every response
      for (int it = 0; it < 80; it++) begin
         int          i;
         logic [1:0]  a;
         logic        r;
         logic [31:0] d;
         i = int'($urandom_range(0, 1));
         a = 2'($urandom_range(0, 3));
         r = 1'($urandom_range(0, 1));
         case (a)
            2'd0:    d = 32'($urandom_range(0, 3));
            2'd1:    d = 32'($urandom_range(0, 1));
            default: d = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'($urandom_range(0, 12));
         endcase
         access(i, a, r, d, v);
         repeat ($urandom_range(0, 3)) tick();
      end

      // Reset during WAIT of an EXPR write aborts it
      tick();
      cs_n[1] = 0; as_n[1] = 0; addr_i[1] = 2'd2; rw_i[1] = 0; wd_i[1] = 32'h55;
      tick();
      tick();
      cs_n[1] = 1; as_n[1] = 1;
      reset = 1;
      lows = 0;
      repeat (2) begin tick(); if (rdy_o[1] === 1'b0) lows++; end
      reset = 0;
      repeat (6) begin tick(); if (rdy_o[1] === 1'b0) lows++; end
      chk("reset_mid_wait_no_rdy", 32'(lows), 32'd0);
      chk("reset_mid_wait_irq", {31'd0, irq_o[1]}, 32'd0);
      rd(1, 2'd2, v); chk("reset_mid_wait_expr", v, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
